// File: rtl/stream_axis_pkg.sv
// Shared types and constants for the encoded-stream drain and AXI-Stream packer.
package stream_axis_pkg;

   typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} drain_state_t;

   localparam int unsigned AXIS_BYTES     = 4;
   localparam int unsigned RD_LAT_DEFAULT = 2;

   // Lane enables for a word whose last filled lane is 'last_lane'.
   function automatic logic [3:0] keep_mask(input logic [1:0] last_lane);
      unique case (last_lane)
         2'd0:    keep_mask = 4'b0001;
         2'd1:    keep_mask = 4'b0011;
         2'd2:    keep_mask = 4'b0111;
         default: keep_mask = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; DEPTH must be a power of 2.
module byte_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      count_q;
   logic             full, do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A push at full is legal only when the same cycle frees a slot.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rptr_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   push_not_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && full && !do_pop));

endmodule

// File: rtl/stream_axis_drain.sv
// Drains an encoded stream via paired reads, buffers returned bytes with credit flow control
// and packs them little-endian into 32-bit AXI-Stream words with TKEEP/TLAST.
module stream_axis_drain
   import stream_axis_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned COUNT_W    = 16,
   parameter int unsigned RD_LAT     = RD_LAT_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [COUNT_W-1:0] byte_count,
   output logic               busy,
   output logic               done,
   output logic               read_en,
   input  logic [7:0]         byte_in,
   input  logic               byte_valid,
   output logic [31:0]        m_axis_tdata,
   output logic [3:0]         m_axis_tkeep,
   output logic               m_axis_tlast,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready
);

   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned LANE_W = $clog2(AXIS_BYTES);

   drain_state_t       state_q, state_d;
   logic [COUNT_W-1:0] rd_remaining_q, rd_remaining_d, rx_remaining_q, rx_remaining_d;
   logic [CNT_W-1:0]   in_flight_q, in_flight_d, fifo_count;
   logic               pair_second_q, pair_second_d;
   logic [LANE_W-1:0]  lane_q, lane_d;
   logic [31:0]        acc_q, acc_d, tdata_q, tdata_d, merged;
   logic [3:0]         tkeep_q, tkeep_d;
   logic               tlast_q, tlast_d, tvalid_q, tvalid_d;
   logic [CNT_W:0]     credit_sum;
   logic               can_pair, last_read, final_hs, byte_accept;
   logic               fifo_pop, fifo_empty, slot_free, word_end;
   logic [7:0]         fifo_rdata;

   // Reserve room for both bytes of a pair before its first read goes out.
   assign credit_sum  = {1'b0, fifo_count} + {1'b0, in_flight_q} + (CNT_W+1)'(2);
   assign can_pair    = (credit_sum <= (CNT_W+1)'(FIFO_DEPTH)) &&
                        (rd_remaining_q >= COUNT_W'(2));
   assign last_read   = (state_q == DRAIN) && pair_second_q && (rd_remaining_q == COUNT_W'(1));
   assign final_hs    = tvalid_q && m_axis_tready && tlast_q;
   assign byte_accept = byte_valid && (in_flight_q != '0);
   assign slot_free   = !tvalid_q || m_axis_tready;
   assign word_end    = (lane_q == LANE_W'(AXIS_BYTES - 1)) || (rx_remaining_q == COUNT_W'(1));
   assign fifo_pop    = !fifo_empty && (rx_remaining_q != '0) && (!word_end || slot_free);
   assign merged      = acc_q | (32'(fifo_rdata) << {lane_q, 3'b000});

   byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (byte_accept),
      .wdata (byte_in),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = (byte_count != '0) ? DRAIN : DONE;
         DRAIN:   if (last_read) state_d = FLUSH;
         FLUSH:   if (final_hs) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state_q != IDLE);
      done    = (state_q == DONE);
      read_en = (state_q == DRAIN) && (pair_second_q || can_pair);
   end

   always_comb begin
      rd_remaining_d = rd_remaining_q;
      rx_remaining_d = rx_remaining_q;
      pair_second_d  = pair_second_q;
      in_flight_d    = in_flight_q;
      lane_d         = lane_q;
      acc_d          = acc_q;
      tdata_d        = tdata_q;
      tkeep_d        = tkeep_q;
      tlast_d        = tlast_q;
      tvalid_d       = tvalid_q;
      if (state_q == IDLE && start) begin
         rd_remaining_d = byte_count;
         rx_remaining_d = byte_count;
         lane_d         = '0;
         acc_d          = '0;
      end
      if (read_en) begin
         rd_remaining_d = rd_remaining_q - COUNT_W'(1);
         pair_second_d  = !pair_second_q;
      end
      case ({read_en, byte_accept})
         2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
         2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
         default: in_flight_d = in_flight_q;
      endcase
      if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;
      if (fifo_pop) begin
         rx_remaining_d = rx_remaining_q - COUNT_W'(1);
         if (word_end) begin
            tdata_d  = merged;
            tkeep_d  = keep_mask(lane_q);
            tlast_d  = (rx_remaining_q == COUNT_W'(1));
            tvalid_d = 1'b1;
            acc_d    = '0;
            lane_d   = '0;
         end else begin
            acc_d  = merged;
            lane_d = lane_q + LANE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_remaining_q <= '0;
         rx_remaining_q <= '0;
         pair_second_q  <= 1'b0;
         in_flight_q    <= '0;
         lane_q         <= '0;
         acc_q          <= '0;
         tdata_q        <= '0;
         tkeep_q        <= '0;
         tlast_q        <= 1'b0;
         tvalid_q       <= 1'b0;
      end else begin
         rd_remaining_q <= rd_remaining_d;
         rx_remaining_q <= rx_remaining_d;
         pair_second_q  <= pair_second_d;
         in_flight_q    <= in_flight_d;
         lane_q         <= lane_d;
         acc_q          <= acc_d;
         tdata_q        <= tdata_d;
         tkeep_q        <= tkeep_d;
         tlast_q        <= tlast_d;
         tvalid_q       <= tvalid_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tkeep  = tkeep_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tvalid = tvalid_q;

   no_stray_byte: assert property (@(posedge clk) disable iff (!rst_n)
      byte_valid |-> (in_flight_q != '0));
   in_flight_bound: assert property (@(posedge clk) disable iff (!rst_n)
      in_flight_q <= CNT_W'(RD_LAT));

endmodule

// File: tb/tb_stream_axis_drain.sv
// Directed bench: models the upstream 2-cycle buffer and checks every output beat
// against a queue of words built from the byte stream.
module tb_stream_axis_drain;

   logic        clk = 1'b0;
   logic        rst_n, start, busy, done, read_en, byte_valid;
   logic [15:0] byte_count;
   logic [7:0]  byte_in;
   logic [31:0] tdata;
   logic [3:0]  tkeep;
   logic        tlast, tvalid, tready;

   always #5 clk = ~clk;

   stream_axis_drain #(
      .FIFO_DEPTH (8),
      .COUNT_W    (16),
      .RD_LAT     (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .byte_count    (byte_count),
      .busy          (busy),
      .done          (done),
      .read_en       (read_en),
      .byte_in       (byte_in),
      .byte_valid    (byte_valid),
      .m_axis_tdata  (tdata),
      .m_axis_tkeep  (tkeep),
      .m_axis_tlast  (tlast),
      .m_axis_tvalid (tvalid),
      .m_axis_tready (tready)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } beat_t;

   beat_t exp_q[$];
   int    errors = 0, checks = 0;
   int    reads_seen = 0, words_seen = 0, run_len = 0;
   int    up_seed = 0, up_idx = 0;
   bit    prev_stall = 0, prev_final = 0;
   beat_t prev_beat, got;
   logic [1:0] pv = '0;
   logic [7:0] pd0 = '0, pd1 = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Expected words: stream byte i is (seed+i+1), packed little-endian, 4 per word.
   task automatic build(input int count, input int seed);
      for (int b = 0; b < count; b += 4) begin
         beat_t w;
         w = '0;
         for (int l = 0; l < 4; l++) begin
            if (b + l < count) begin
               w.data[8*l +: 8] = 8'(seed + b + l + 1);
               w.keep[l]        = 1'b1;
            end
         end
         w.last = (b + 4 >= count);
         exp_q.push_back(w);
      end
   endtask

   // Compare process: every cycle, half a period away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         prev_stall = 0;
         prev_final = 0;
         run_len    = 0;
      end else begin
         if (prev_final) check("done_after_last", done, 1);
         if (prev_stall) begin
            check("hold_valid", tvalid, 1);
            check("hold_data", tdata, prev_beat.data);
            check("hold_keep", tkeep, prev_beat.keep);
            check("hold_last", tlast, prev_beat.last);
         end
         if (read_en) begin
            reads_seen++;
            run_len++;
         end else begin
            if (run_len != 0) check("read_pair_even", run_len % 2, 0);
            run_len = 0;
         end
         if ((read_en || tvalid) && !busy) check("quiet_when_idle", {read_en, tvalid}, 0);
         if (tvalid && tready) begin
            words_seen++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_beat: got %h, expected no beat", tdata);
            end else begin
               got = exp_q.pop_front();
               check("beat_data", tdata, got.data);
               check("beat_keep", tkeep, got.keep);
               check("beat_last", tlast, got.last);
            end
         end
         prev_stall     = tvalid && !tready;
         prev_final     = tvalid && tready && tlast;
         prev_beat.data = tdata;
         prev_beat.keep = tkeep;
         prev_beat.last = tlast;
      end
   end

   // Advance one cycle; upstream returns a byte exactly two cycles after each read_en.
   task automatic step();
      @(posedge clk);
      #1;
      if (!rst_n) begin
         pv         = '0;
         byte_valid = 1'b0;
         byte_in    = '0;
      end else begin
         byte_valid = pv[1];
         byte_in    = pd1;
         pv[1]      = pv[0];
         pd1        = pd0;
         pv[0]      = read_en;
         pd0        = 8'(up_seed + up_idx + 1);
         if (read_en) up_idx++;
      end
   endtask

   task automatic issue(input int count, input int seed);
      byte_count = 16'(count);
      up_seed    = seed;
      up_idx     = 0;
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   task automatic finish_stream(input string name, input int budget, input int r0,
                                input int nreads);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (done) begin
            ok = 1;
            break;
         end
         step();
      end
      check({name, "_done_seen"}, ok, 1);
      check({name, "_read_count"}, reads_seen - r0, nreads);
      check({name, "_words_left"}, exp_q.size(), 0);
      step();
      check({name, "_idle_after"}, {busy, done}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int r0, w0, r1;
      rst_n = 1'b0; start = 1'b0; byte_count = '0; byte_valid = 1'b0; byte_in = '0;
      tready = 1'b1;
      repeat (3) step();
      check("reset_ctrl", {busy, done, read_en, tvalid, tlast, tkeep}, 0);
      check("reset_data", tdata, 0);
      rst_n = 1'b1;
      step();

      // 1: eight bytes, sink always ready
      build(8, 0);
      check("model_w0", exp_q[0].data, 32'h04030201);
      check("model_w1", exp_q[1].data, 32'h08070605);
      check("model_w1_last", exp_q[1].last, 1);
      r0 = reads_seen;
      issue(8, 0);
      check("first_read_latency", read_en, 1);
      finish_stream("t1", 100, r0, 8);

      // 2: six bytes, partial final word
      build(6, 0);
      check("model_tail_data", exp_q[1].data, 32'h00000605);
      check("model_tail_keep", exp_q[1].keep, 4'h3);
      r0 = reads_seen;
      issue(6, 0);
      finish_stream("t2", 100, r0, 6);

      // 3: 64 bytes with a 20-cycle sink stall mid-stream
      build(64, 8'h40);
      r0 = reads_seen;
      w0 = words_seen;
      issue(64, 8'h40);
      repeat (10) step();
      tready = 1'b0;
      repeat (12) step();
      r1 = reads_seen;
      repeat (8) step();
      check("stall_no_reads", reads_seen - r1, 0);
      check("stall_tvalid", tvalid, 1);
      tready = 1'b1;
      finish_stream("t3", 600, r0, 64);
      check("t3_words", words_seen - w0, 16);

      // 4: zero-length stream
      r0 = reads_seen;
      w0 = words_seen;
      issue(0, 0);
      check("zero_busy_done", {busy, done}, 2'b11);
      step();
      check("zero_back_idle", {busy, done}, 2'b00);
      repeat (3) step();
      check("zero_no_reads", reads_seen - r0, 0);
      check("zero_no_words", words_seen - w0, 0);

      // 5: start during DRAIN is ignored
      build(8, 8'h20);
      r0 = reads_seen;
      issue(8, 8'h20);
      step();
      byte_count = 16'd20;
      start      = 1'b1;
      step();
      start      = 1'b0;
      finish_stream("t5", 100, r0, 8);

      // 6: reset while holding the first word in FLUSH, then a clean 4-byte stream
      build(8, 8'h30);
      tready = 1'b0;
      issue(8, 8'h30);
      repeat (14) step();
      check("t6_pre_reset", {busy, tvalid}, 2'b11);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_ctrl", {busy, done, read_en, tvalid, tlast, tkeep}, 0);
      check("t6_async_data", tdata, 0);
      repeat (2) step();
      rst_n  = 1'b1;
      tready = 1'b1;
      step();
      build(4, 8'h10);
      check("model_single", exp_q[0].data, 32'h14131211);
      check("model_single_kl", {exp_q[0].keep, exp_q[0].last}, 5'b11111);
      r0 = reads_seen;
      issue(4, 8'h10);
      finish_stream("t6", 100, r0, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
